// File: rtl/cpu_controller.sv
// cpu_controller
//   Moore FSM that sequences a simple register-file/ALU datapath.
//   It holds a 16-bit instruction register (IR) and decodes fields from it.
//   Every output is a function of the current state and the IR only.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   s                    start executing the held instruction
//   load, in[15:0]       IR load enable and instruction word (honoured in WAIT only)
//   w                    ready flag, high only in WAIT
//   writenum/readnumA/B  register-file addresses
//   write, loada/b/c/s   register-file and pipeline-register enables
//   asel, bsel           operand selects (asel: Ain=0, bsel: sximm5)
//   vsel                 writeback select (00 mdata, 01 sximm8, 10 PC, 11 C)
//   shift, ALUop         shifter and ALU controls
//   sximm8, sximm5       sign-extended immediates from the IR
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  writenum,
  output logic [2:0]  readnumA,
  output logic [2:0]  readnumB,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WIMM   = 3'd2,
    S_RDAB   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Instruction classes
  logic is_movi, is_movr, is_alu, is_cmp;
  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (load && state == S_WAIT) ir <= in;
    end
  end

  always_comb begin
    state_nxt = state;
    w         = 1'b0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    shift     = 2'b00;
    ALUop     = 2'b00;
    writenum  = rd;
    readnumA  = rn;
    readnumB  = rm;

    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)               state_nxt = S_WIMM;
        else if (is_movr || is_alu) state_nxt = S_RDAB;
        else                       state_nxt = S_WAIT;
      end
      S_WIMM: begin
        write     = 1'b1;
        vsel      = 2'b01;
        writenum  = rn;
        state_nxt = S_WAIT;
      end
      S_RDAB: begin
        loada     = 1'b1;
        loadb     = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        if (is_movr) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          // ALU group: op field maps straight onto ALUop (ADD/CMP/AND/MVN)
          ALUop = op;
        end
        if (is_cmp) begin
          loads     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          loadc     = 1'b1;
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        write     = 1'b1;
        vsel      = 2'b11;
        writenum  = rd;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

  logic        clk, reset, s, load;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  writenum, readnumA, readnumB;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int passed = 0;
  int total  = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .writenum(writenum), .readnumA(readnumA), .readnumB(readnumB),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  // enable bundle {write,loada,loadb,loadc,loads,asel,bsel}
  logic [6:0] en;
  assign en = {write, loada, loadb, loadc, loads, asel, bsel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [15:0] word);
    in = word; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    #3;
    total++;
    if ({w, en, sximm8, sximm5} !== {1'b1, 7'b0, 16'h0, 16'h0})
      $display("FAIL reset_outputs: got w=%b en=%b sx8=%h sx5=%h want w=1 en=0 sx8=0 sx5=0", w, en, sximm8, sximm5);
    else passed++;
    step();
    reset = 1'b0;
    step();
    total++;
    if (w !== 1'b1) $display("FAIL reset_idle: got w=%b want 1", w); else passed++;
  endtask

  task automatic test_mov_imm();
    load_ir(16'hD105);
    s = 1'b1; step(); s = 1'b0;             // edge 1 -> DECODE
    total++;
    if ({w, en} !== 8'b0) $display("FAIL movi_decode: got w=%b en=%b want 0/0", w, en); else passed++;
    step();                                  // edge 2 -> WIMM
    total++;
    if ({w, en, vsel, writenum, sximm8} !== {1'b0, 7'b1000000, 2'b01, 3'd1, 16'h0005})
      $display("FAIL movi_wimm: got w=%b en=%b vsel=%b wn=%0d sx8=%h want 0/1000000/01/1/0005", w, en, vsel, writenum, sximm8);
    else passed++;
    step();                                  // edge 3 -> WAIT
    total++;
    if ({w, write} !== 2'b10) $display("FAIL movi_latency: got w=%b write=%b want w=1 write=0", w, write); else passed++;
  endtask

  task automatic test_neg_imm();
    load_ir(16'hD2F8);
    total++;
    if ({sximm8, sximm5} !== {16'hFFF8, 16'hFFF8})
      $display("FAIL neg_imm: got sx8=%h sx5=%h want FFF8/FFF8", sximm8, sximm5);
    else passed++;
  endtask

  task automatic test_add();
    load_ir(16'hA0A9);
    s = 1'b1; step(); s = 1'b0;              // DECODE
    step();                                  // RDAB
    total++;
    if ({en, readnumA, readnumB} !== {7'b0110000, 3'd0, 3'd1})
      $display("FAIL add_rdab: got en=%b rA=%0d rB=%0d want 0110000/0/1", en, readnumA, readnumB);
    else passed++;
    step();                                  // EXEC
    total++;
    if ({en, ALUop, shift} !== {7'b0001000, 2'b00, 2'b01})
      $display("FAIL add_exec: got en=%b alu=%b sh=%b want 0001000/00/01", en, ALUop, shift);
    else passed++;
    step();                                  // WB
    total++;
    if ({en, vsel, writenum, w} !== {7'b1000000, 2'b11, 3'd5, 1'b0})
      $display("FAIL add_wb: got en=%b vsel=%b wn=%0d w=%b want 1000000/11/5/0", en, vsel, writenum, w);
    else passed++;
    step();                                  // edge 5 -> WAIT
    total++;
    if (w !== 1'b1) $display("FAIL add_latency: got w=%b want 1", w); else passed++;
  endtask

  task automatic test_cmp();
    logic saw_write;
    int   rise;
    saw_write = 1'b0; rise = 0;
    load_ir(16'hA901);
    s = 1'b1; step(); s = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) step();
      if (write) saw_write = 1'b1;
      if (i == 3) begin                      // EXEC after DECODE, RDAB
        total++;
        if ({loads, loadc, ALUop} !== {1'b1, 1'b0, 2'b01})
          $display("FAIL cmp_exec: got loads=%b loadc=%b alu=%b want 1/0/01", loads, loadc, ALUop);
        else passed++;
      end
      if (w && rise == 0) rise = i;
    end
    total++;
    if (rise != 4) $display("FAIL cmp_latency: got %0d edges want 4", rise); else passed++;
    total++;
    if (saw_write) $display("FAIL cmp_no_write: got write pulse want none"); else passed++;
  endtask

  task automatic test_reset_mid();
    logic saw_write;
    saw_write = 1'b0;
    load_ir(16'hA0A9);
    s = 1'b1; step(); s = 1'b0;              // DECODE
    step();                                  // RDAB
    reset = 1'b1;
    #1;
    total++;
    if ({w, en} !== {1'b1, 7'b0}) $display("FAIL rst_mid_w: got w=%b en=%b want 1/0", w, en); else passed++;
    total++;
    if ({sximm8, writenum, readnumA, readnumB} !== {16'h0, 3'd0, 3'd0, 3'd0})
      $display("FAIL rst_mid_ir: got sx8=%h wn=%0d rA=%0d rB=%0d want IR=0", sximm8, writenum, readnumA, readnumB);
    else passed++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (write || !w) saw_write = 1'b1;
    end
    total++;
    if (saw_write) $display("FAIL rst_mid_nowrite: got activity after reset want idle"); else passed++;
  endtask

  task automatic test_load_gating();
    load_ir(16'hA0A9);
    s = 1'b1; step(); s = 1'b0;              // DECODE
    step(); step();                          // RDAB, EXEC
    in = 16'hD2F8; load = 1'b1;
    step();                                  // WB, load ignored
    load = 1'b0;
    total++;
    if ({writenum, sximm8} !== {3'd5, 16'hFFA9})
      $display("FAIL load_gating: got wn=%0d sx8=%h want 5/FFA9", writenum, sximm8);
    else passed++;
    step();                                  // WAIT
  endtask

  task automatic test_undefined();
    logic any_en;
    any_en = 1'b0;
    load_ir(16'hE000);
    s = 1'b1; step(); s = 1'b0;              // DECODE
    if (en != 7'b0 || w) any_en = 1'b1;
    step();                                  // back to WAIT
    total++;
    if (w !== 1'b1) $display("FAIL undef_latency: got w=%b want 1 after 2 edges", w); else passed++;
    total++;
    if (any_en || en != 7'b0) $display("FAIL undef_enables: got en=%b want 0", en); else passed++;
  endtask

  task automatic test_back_to_back();
    load_ir(16'hD105);
    s = 1'b1;
    step(); step(); step();                  // DECODE, WIMM, WAIT
    total++;
    if (w !== 1'b1) $display("FAIL b2b_wait: got w=%b want 1", w); else passed++;
    step();                                  // DECODE again
    total++;
    if (w !== 1'b0) $display("FAIL b2b_rerun: got w=%b want 0", w); else passed++;
    s = 1'b0;
    step();                                  // WIMM of rerun
    total++;
    if ({write, vsel, writenum} !== {1'b1, 2'b01, 3'd1})
      $display("FAIL b2b_write: got write=%b vsel=%b wn=%0d want 1/01/1", write, vsel, writenum);
    else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_neg_imm();
    test_add();
    test_cmp();
    test_reset_mid();
    test_load_gating();
    test_undefined();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
